// File: rtl/gray_pkg.sv
// Shared definitions for the Gray-coded step counter: direction encodings
// and the binary-to-Gray conversion used on the output path.
package gray_pkg;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Widest count supported by bin2gray; callers zero-extend into it and
    // truncate the result back to their own width.
    localparam int GRAY_MAX_W = 64;

    // Reflected binary code: adjacent binary values differ in one Gray bit.
    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

endpackage

// File: rtl/gray_step_counter_prescaler.sv
// Step prescaler: counts enabled cycles and fires a one-cycle step every
// div_max+1 enabled cycles. Owns the runtime-programmable compare value.
module step_prescaler
    import gray_pkg::*;
#(
    parameter int          DIV_WIDTH = 32,
    parameter int unsigned DIV_RST   = 17_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 div_we,
    input  logic [DIV_WIDTH-1:0] div_in,
    output logic                 step
);

    logic [DIV_WIDTH-1:0] pcnt;
    logic [DIV_WIDTH-1:0] div_max;

    // ">=" rather than "==" so that lowering div_max below the running count
    // still produces a step on the next enabled cycle instead of a long wrap.
    // A clear on the same edge suppresses the step: the load owns that edge.
    assign step = en && !clr && (pcnt >= div_max);

    // Prescale counter: cleared by reset or load, held while disabled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pcnt <= '0;
        end else if (clr) begin
            pcnt <= '0;
        end else if (en) begin
            if (pcnt >= div_max) begin
                pcnt <= '0;
            end else begin
                pcnt <= pcnt + 1'b1;
            end
        end
    end

    // Compare register: written independently of load/stop; the new value
    // takes effect from the following cycle.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_max <= DIV_WIDTH'(DIV_RST);
        end else if (div_we) begin
            div_max <= div_in;
        end
    end

endmodule

// File: rtl/gray_step_counter.sv
// Up/down counter with prescaled stepping, parallel load and wrap/saturate
// behaviour at the ends. Binary and Gray outputs are registered together so
// they never skew; tick marks every step, term marks wrapped or blocked steps.
module gray_step_counter
    import gray_pkg::*;
#(
    parameter int          WIDTH     = 8,
    parameter int          DIV_WIDTH = 32,
    parameter int unsigned DIV_RST   = 17_000_000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 div_we,
    input  logic [DIV_WIDTH-1:0] div_in,
    input  logic                 incdec,
    input  logic                 stop,
    input  logic                 sat,
    input  logic                 load,
    input  logic [WIDTH-1:0]     load_val,
    output logic [WIDTH-1:0]     normal,
    output logic [WIDTH-1:0]     gray,
    output logic                 tick,
    output logic                 term
);

    localparam logic [WIDTH-1:0] ALL_ONES = '1;
    localparam logic [WIDTH-1:0] ZERO     = '0;

    logic             step;
    logic             at_end;
    logic             next_term;
    logic [WIDTH-1:0] next_count;
    logic [WIDTH-1:0] sel_bin;
    logic [WIDTH-1:0] sel_gray;

    step_prescaler #(
        .DIV_WIDTH (DIV_WIDTH),
        .DIV_RST   (DIV_RST)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (~stop),
        .clr    (load),
        .div_we (div_we),
        .div_in (div_in),
        .step   (step)
    );

    // Next count for a step: detect the end in the current direction, then
    // wrap or hold; a step at the end always raises term.
    always_comb begin
        next_count = normal;
        next_term  = 1'b0;
        at_end     = (incdec == DIR_UP) ? (normal == ALL_ONES) : (normal == ZERO);
        if (at_end) begin
            next_term = 1'b1;
            if (!sat) begin
                next_count = (incdec == DIR_UP) ? ZERO : ALL_ONES;
            end
        end else if (incdec == DIR_UP) begin
            next_count = normal + 1'b1;
        end else begin
            next_count = normal - 1'b1;
        end
        // One conversion serves both the load value and the stepped value,
        // so the Gray register always tracks what lands in the binary one.
        sel_bin  = load ? load_val : next_count;
        sel_gray = WIDTH'(bin2gray(GRAY_MAX_W'(sel_bin)));
    end

    // Output registers: reset > load > step; pulses are zero unless a step fires.
    always_ff @(posedge clk) begin
        if (!rst) begin
            normal <= '0;
            gray   <= '0;
            tick   <= 1'b0;
            term   <= 1'b0;
        end else if (load) begin
            normal <= sel_bin;
            gray   <= sel_gray;
            tick   <= 1'b0;
            term   <= 1'b0;
        end else if (step) begin
            normal <= sel_bin;
            gray   <= sel_gray;
            tick   <= 1'b1;
            term   <= next_term;
        end else begin
            tick   <= 1'b0;
            term   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gray_step_counter.sv
// Bench for gray_step_counter (WIDTH=4, DIV_RST=2): directed scenarios then
// randomized traffic, all compared against a cycle-level behavioural model.
module tb_gray_step_counter;

    localparam int W       = 4;
    localparam int DW      = 32;
    localparam int DIV_RST = 2;
    localparam int MAXV    = (1 << W) - 1;

    logic          clk;
    logic          rst;
    logic          div_we;
    logic [DW-1:0] div_in;
    logic          incdec;
    logic          stop;
    logic          sat;
    logic          load;
    logic [W-1:0]  load_val;
    logic [W-1:0]  normal;
    logic [W-1:0]  gray;
    logic          tick;
    logic          term;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    int   m_pcnt, m_dmax, m_cnt;
    logic m_tick, m_term;
    logic [W-1:0] gray_tab[1 << W];

    int n_ticks, n_terms;

    gray_step_counter #(
        .WIDTH     (W),
        .DIV_WIDTH (DW),
        .DIV_RST   (DIV_RST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .div_we   (div_we),
        .div_in   (div_in),
        .incdec   (incdec),
        .stop     (stop),
        .sat      (sat),
        .load     (load),
        .load_val (load_val),
        .normal   (normal),
        .gray     (gray),
        .tick     (tick),
        .term     (term)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Gray table built by reflection, independent of any xor formula.
    task automatic build_gray_tab();
        gray_tab[0] = '0;
        for (int k = 0; k < W; k++) begin
            for (int i = 0; i < (1 << k); i++) begin
                gray_tab[(1 << k) + i] = gray_tab[(1 << k) - 1 - i] | W'(1 << k);
            end
        end
    endtask

    // Advance the model by one clock edge using the inputs currently driven.
    task automatic model_edge();
        logic fire;
        fire = 1'b0;
        if (!rst) begin
            m_pcnt = 0; m_dmax = DIV_RST; m_cnt = 0; m_tick = 0; m_term = 0;
        end else begin
            m_tick = 0;
            m_term = 0;
            if (load) begin
                m_cnt  = int'(load_val);
                m_pcnt = 0;
            end else if (!stop) begin
                if (m_pcnt >= m_dmax) begin
                    m_pcnt = 0;
                    fire   = 1'b1;
                end else begin
                    m_pcnt++;
                end
            end
            if (fire) begin
                m_tick = 1;
                if (incdec) begin
                    if (m_cnt == MAXV) begin
                        m_term = 1;
                        if (!sat) m_cnt = 0;
                    end else m_cnt++;
                end else begin
                    if (m_cnt == 0) begin
                        m_term = 1;
                        if (!sat) m_cnt = MAXV;
                    end else m_cnt--;
                end
            end
            if (div_we) m_dmax = int'(div_in);
        end
    endtask

    // One clock: update model at the edge, compare 1ns later.
    task automatic cycle();
        logic [W-1:0] prev_gray;
        logic [W-1:0] prev_norm;
        logic         was_load;
        prev_gray = gray;
        prev_norm = normal;
        was_load  = load && rst;
        @(posedge clk);
        model_edge();
        #1;
        check("normal", 32'(normal), 32'(m_cnt));
        check("gray",   32'(gray),   32'(gray_tab[m_cnt]));
        check("tick",   32'(tick),   32'(m_tick));
        check("term",   32'(term),   32'(m_term));
        if (tick) n_ticks++;
        if (term) n_terms++;
        if (tick && !was_load && normal != prev_norm)
            check("gray_one_bit", 32'($countones(gray ^ prev_gray)), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic do_load(input logic [W-1:0] v);
        load = 1'b1; load_val = v;
        cycle();
        load = 1'b0;
    endtask

    task automatic write_div(input int v);
        div_we = 1'b1; div_in = DW'(v);
        cycle();
        div_we = 1'b0;
    endtask

    initial begin
        build_gray_tab();
        m_pcnt = 0; m_dmax = DIV_RST; m_cnt = 0; m_tick = 0; m_term = 0;
        rst = 1'b0; div_we = 0; div_in = '0; incdec = 1; stop = 0; sat = 0;
        load = 0; load_val = '0;

        // 1: reset, then a full up count with wrap
        run(2);
        check("reset_normal", 32'(normal), 32'd0);
        rst = 1'b1;
        n_ticks = 0; n_terms = 0;
        run(48);
        check("p1_ticks", 32'(n_ticks), 32'd16);
        check("p1_terms", 32'(n_terms), 32'd1);
        check("p1_wrap",  32'(normal),  32'd0);

        // 2: saturation up at 15, then down, then hold at 0
        sat = 1; do_load(4'hE);
        run(9);
        check("sat_hold_15", 32'(normal), 32'd15);
        incdec = 0; run(3);
        check("sat_down_14", 32'(normal), 32'd14);
        do_load(4'h0); run(6);
        check("sat_hold_0", 32'(normal), 32'd0);
        sat = 0; incdec = 1;

        // 3: stop mid-period, release resumes
        do_load(4'h3); run(1);
        stop = 1; n_ticks = 0; run(10);
        check("stop_no_tick", 32'(n_ticks), 32'd0);
        stop = 0; run(1);
        check("resume_c1", 32'(tick), 32'd0);
        run(1);
        check("resume_c2", 32'(tick), 32'd1);

        // 4: runtime divide ratio changes
        write_div(0); run(4);
        write_div(10); do_load(4'h0); run(4);
        write_div(5); run(8);
        write_div(10); do_load(4'h0); run(6);
        write_div(3); run(6);

        // 5: load with stop on a would-be step edge
        write_div(0); stop = 1; do_load(4'h9);
        check("load9_normal", 32'(normal), 32'h9);
        check("load9_gray",   32'(gray),   32'hD);
        check("load9_tick",   32'(tick),   32'd0);
        stop = 0; run(3);

        // 6: reset wins over stop and load
        write_div(7); run(3);
        stop = 1; load = 1; load_val = 4'h5; rst = 0;
        cycle();
        check("rst_normal", 32'(normal), 32'd0);
        check("rst_tick",   32'(tick),   32'd0);
        stop = 0; load = 0; rst = 1;
        run(9);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rst      = ($urandom_range(0, 199) != 0);
            load     = ($urandom_range(0, 39) == 0);
            load_val = W'($urandom_range(0, MAXV));
            div_we   = ($urandom_range(0, 49) == 0);
            div_in   = DW'($urandom_range(0, 6));
            stop     = ($urandom_range(0, 4) == 0);
            incdec   = 1'($urandom_range(0, 1));
            sat      = 1'($urandom_range(0, 1));
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
